// File: rtl/rr_arbiter_n_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_n_if
// Description : Request/grant bundle between requesters and rr_arbiter_n.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_arbiter_n_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               busy;
  logic               preempt;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  preempt
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output busy,
    output preempt
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_n
// Description : N-way arbiter, round-robin or fixed priority, with direct
//               handover and bounded hold time (preemption).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_n #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_HOLD  = 8,
  parameter int PRIO_MODE = 0
) (
  input  logic          clock,
  input  logic          reset,
  rr_arbiter_n_if.slave arb
);
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HC_W        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_LAST_I);
  localparam logic [ID_W-1:0] PTR_RESET = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b01,
    S_GRANT = 2'b10
  } state_t;

  state_t             state, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               busy_q;
  logic               preempt_q, preempt_d;
  logic [HC_W-1:0]    hold_cnt, hold_d;
  logic [ID_W-1:0]    rr_ptr, ptr_d;

  logic [NUM_REQ-1:0] others;
  logic               owner_req;
  logic [ID_W-1:0]    win_all, win_oth;

  // Descending scans so the highest-priority candidate is written last.
  function automatic logic [ID_W-1:0] pick_winner(
    input logic [NUM_REQ-1:0] cand,
    input logic [ID_W-1:0]    ptr
  );
    logic [ID_W-1:0] win;
    int              idx;
    win = '0;
    if (PRIO_MODE != 0) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (cand[ID_W'(i)]) win = ID_W'(i);
      end
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        idx = (int'(ptr) + k) % NUM_REQ;
        if (cand[ID_W'(idx)]) win = ID_W'(idx);
      end
    end
    return win;
  endfunction

  always_comb begin
    state_d   = state;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    preempt_d = 1'b0;
    hold_d    = hold_cnt;
    ptr_d     = rr_ptr;
    others    = arb.req & ~gnt_q;
    owner_req = |(arb.req & gnt_q);
    win_all   = pick_winner(arb.req, rr_ptr);
    win_oth   = pick_winner(others, rr_ptr);

    case (state)
      S_IDLE: begin
        if (|arb.req) begin
          state_d  = S_GRANT;
          gnt_d    = NUM_REQ'(1) << win_all;
          gnt_id_d = win_all;
          hold_d   = '0;
          if (PRIO_MODE == 0) ptr_d = win_all;
        end
      end
      S_GRANT: begin
        if (!owner_req) begin
          if (|others) begin
            gnt_d    = NUM_REQ'(1) << win_oth;
            gnt_id_d = win_oth;
            hold_d   = '0;
            if (PRIO_MODE == 0) ptr_d = win_oth;
          end else begin
            state_d  = S_IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            hold_d   = '0;
          end
        end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && (|others)) begin
          gnt_d     = NUM_REQ'(1) << win_oth;
          gnt_id_d  = win_oth;
          hold_d    = '0;
          preempt_d = 1'b1;
          if (PRIO_MODE == 0) ptr_d = win_oth;
        end else if (hold_cnt != HOLD_LAST) begin
          // Saturates at HOLD_LAST so a lone owner never wraps into a preempt.
          hold_d = hold_cnt + HC_W'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
        hold_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
      hold_cnt  <= '0;
      rr_ptr    <= PTR_RESET;
    end else begin
      state     <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= |gnt_d;
      preempt_q <= preempt_d;
      hold_cnt  <= hold_d;
      rr_ptr    <= ptr_d;
    end
  end

  assign arb.gnt     = gnt_q;
  assign arb.gnt_id  = gnt_id_q;
  assign arb.busy    = busy_q;
  assign arb.preempt = preempt_q;
endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter_n
// Description : Scoreboard bench for rr_arbiter_n across several parameter sets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_n;
  localparam int NINST = 8;

  typedef struct {
    logic [15:0] req;
    bit          rst;
    int          owner;
    bit          pre;
  } exp_t;

  function automatic int nr_of(input int g);
    return (g == 7) ? 5 : 4;
  endfunction

  function automatic int mh_of(input int g);
    case (g)
      0:       return 8;
      1:       return 4;
      2:       return 0;
      3:       return 1;
      5:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic int pm_of(input int g);
    return (g == 1 || g == 5 || g == 6) ? 1 : 0;
  endfunction

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] req   = '0;
  logic [15:0] probe_gnt;
  logic        probe_pre;
  int          n_cmp  = 0;
  int          n_fail = 0;

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, want, $time);
    end
  endtask

  for (genvar g = 0; g < NINST; g++) begin : g_inst
    localparam int NR = nr_of(g);
    localparam int MH = mh_of(g);
    localparam int PM = pm_of(g);
    localparam int WB = (NR - 1) * MH + 1;

    rr_arbiter_n_if #(.NUM_REQ(NR)) bus ();
    assign bus.req = req[NR-1:0];

    rr_arbiter_n #(
      .NUM_REQ  (NR),
      .MAX_HOLD (MH),
      .PRIO_MODE(PM)
    ) u_dut (
      .clock(clock),
      .reset(reset),
      .arb  (bus)
    );

    if (g == 0) begin : g_probe
      assign probe_gnt = 16'(bus.gnt);
      assign probe_pre = bus.preempt;
    end

    // Reference: owner index (-1 idle), cycles held, last-granted pointer.
    int   owner = -1;
    int   held  = 0;
    int   ptr   = NR - 1;
    exp_t q[$];
    int   wait_c [NR];

    function automatic int pick(input logic [15:0] v, input int p);
      if (PM == 1) begin
        for (int i = 0; i < NR; i++) if (v[i]) return i;
      end else begin
        for (int k = 1; k <= NR; k++) if (v[(p + k) % NR]) return (p + k) % NR;
      end
      return -1;
    endfunction

    always @(negedge clock) begin
      exp_t        e;
      logic [15:0] v;
      logic [15:0] oth;
      #1;
      v     = req & ((16'(1) << NR) - 16'(1));
      e.pre = 1'b0;
      if (reset) begin
        owner = -1;
        held  = 0;
        ptr   = NR - 1;
      end else if (owner < 0) begin
        if (v != 0) begin
          owner = pick(v, ptr);
          held  = 0;
          if (PM == 0) ptr = owner;
        end
      end else begin
        oth        = v;
        oth[owner] = 1'b0;
        if (!v[owner]) begin
          if (oth != 0) begin
            owner = pick(oth, ptr);
            held  = 0;
            if (PM == 0) ptr = owner;
          end else begin
            owner = -1;
          end
        end else if (MH > 0 && held >= MH - 1 && oth != 0) begin
          owner = pick(oth, ptr);
          held  = 0;
          e.pre = 1'b1;
          if (PM == 0) ptr = owner;
        end else begin
          held++;
        end
      end
      e.req   = v;
      e.rst   = reset;
      e.owner = owner;
      q.push_back(e);
    end

    always @(posedge clock) begin
      exp_t        e;
      logic [63:0] eg;
      string       tag;
      #1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        tag = $sformatf("inst%0d", g);
        eg  = (e.owner < 0) ? 64'd0 : (64'd1 << e.owner);
        chk({tag, ".gnt"},     64'(bus.gnt), eg);
        chk({tag, ".gnt_id"},  64'(bus.gnt_id), (e.owner < 0) ? 64'd0 : 64'(e.owner));
        chk({tag, ".busy"},    64'(bus.busy), 64'(eg != 0));
        chk({tag, ".preempt"}, 64'(bus.preempt), 64'(e.pre));
        chk({tag, ".onehot0"}, 64'($onehot0(bus.gnt)), 64'd1);
        chk({tag, ".busy_or"}, 64'(bus.busy), 64'(|bus.gnt));
        chk({tag, ".unrequested"}, 64'(bus.gnt & ~e.req[NR-1:0]), 64'd0);
        if (PM == 0 && MH > 0) begin
          for (int i = 0; i < NR; i++) begin
            if (!e.rst && e.req[i] && !bus.gnt[i]) wait_c[i]++;
            else wait_c[i] = 0;
            if (wait_c[i] > 0) chk({tag, ".wait_bound"}, 64'(wait_c[i] > WB), 64'd0);
          end
        end
      end
    end
  end

  task automatic step(input logic [15:0] v, input bit r);
    @(negedge clock);
    req   = v;
    reset = r;
  endtask

  task automatic dchk(input string name, input logic [3:0] g_exp, input logic p_exp);
    @(posedge clock);
    #2;
    chk({name, ".gnt"},     64'(probe_gnt), 64'(g_exp));
    chk({name, ".preempt"}, 64'(probe_pre), 64'(p_exp));
  endtask

  initial begin
    logic [15:0] r;
    step(16'h0, 1'b1);
    step(16'h0, 1'b1);
    dchk("reset_state", 4'b0000, 1'b0);

    // All four requesting: each owner keeps the grant for 8 cycles.
    step(16'hF, 1'b0);
    dchk("s1_first_gnt", 4'b0001, 1'b0);
    repeat (7) step(16'hF, 1'b0);
    dchk("s1_hold_end", 4'b0001, 1'b0);
    step(16'hF, 1'b0);
    dchk("s1_preempt_1", 4'b0010, 1'b1);
    repeat (30) step(16'hF, 1'b0);

    step(16'h0, 1'b1);
    repeat (20) step(16'h4, 1'b0);
    dchk("s2_single", 4'b0100, 1'b0);

    step(16'h0, 1'b1);
    step(16'h2, 1'b0);
    dchk("s3_owner1", 4'b0010, 1'b0);
    step(16'hA, 1'b0);
    dchk("s3_hold", 4'b0010, 1'b0);
    step(16'h8, 1'b0);
    dchk("s3_handover", 4'b1000, 1'b0);
    step(16'h0, 1'b0);
    dchk("s3_idle", 4'b0000, 1'b0);

    step(16'h0, 1'b1);
    repeat (30) step(16'hD, 1'b0);

    step(16'h0, 1'b1);
    step(16'h2, 1'b0);
    step(16'h2, 1'b0);
    dchk("s5_pre_reset", 4'b0010, 1'b0);
    step(16'h2, 1'b1);
    dchk("s5_reset", 4'b0000, 1'b0);
    step(16'h3, 1'b0);
    dchk("s5_after_reset", 4'b0001, 1'b0);
    step(16'h1, 1'b0);
    step(16'h1, 1'b1);
    dchk("s5b_reset", 4'b0000, 1'b0);
    step(16'h3, 1'b0);
    dchk("s5b_ptr_restored", 4'b0001, 1'b0);

    r = '0;
    repeat (6000) begin
      for (int b = 0; b < 16; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      step(r, ($urandom_range(0, 599) == 0));
    end
    repeat (3) step(16'h0, 1'b0);
    @(posedge clock);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
